fft_spectrum_reader: RTL and testbench

- Downstream consumer of the radix-2 block-floating-point FFT core.
- When the core reports done, the block drains the lower half of the spectrum (bins 0..N/2-1) through the core's DMA read port.
- For each bin it computes an alpha-max-beta-min magnitude and streams it out over a valid/ready interface, tagged with the frame's BFP exponent.
- At frame end it reports the peak bin and pulses `fft_fin` to release the core for the next input frame.

---
 rtl/fft_spectrum_reader.sv | 217 +++++++++++++++++++++
 tb/tb_fft_spectrum_reader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_spectrum_reader.sv
// -----------------------------------------------------------------------------
// fft_spectrum_reader
//
// Reads the lower half of a finished FFT frame (bins 0..N/2-1) through the
// core's DMA read port, turns each bin into an alpha-max-beta-min magnitude
// and streams it out over valid/ready, tagged with the frame's BFP exponent.
// At frame end it reports the largest bin and pulses fft_fin so the core can
// accept its next input frame.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   enable            gates the start of a new frame only
//   fft_done          core done level; fft_bfpexp is its frame exponent
//   fft_fin           one-cycle release pulse back to the core
//   dmaact, dmaa      DMA read strobe and bin address
//   dmadr_real/imag   DMA read data, valid the cycle after dmaact
//   out_*             magnitude stream (valid/ready, bin, mag, exp, last)
//   peak_valid/bin/mag  frame-end peak report
//   busy              high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module fft_spectrum_reader #(
    parameter int FFT_LENGTH = 1024,
    parameter int FFT_DW     = 16,
    parameter int FFT_N      = $clog2(FFT_LENGTH),
    parameter int MAG_DW     = FFT_DW + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     fft_done,
    input  logic signed [7:0]        fft_bfpexp,
    output logic                     fft_fin,
    output logic                     dmaact,
    output logic [FFT_N-1:0]         dmaa,
    input  logic signed [FFT_DW-1:0] dmadr_real,
    input  logic signed [FFT_DW-1:0] dmadr_imag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FFT_N-2:0]         out_bin,
    output logic [MAG_DW-1:0]        out_mag,
    output logic signed [7:0]        out_exp,
    output logic                     out_last,
    output logic                     peak_valid,
    output logic [FFT_N-2:0]         peak_bin,
    output logic [MAG_DW-1:0]        peak_mag,
    output logic                     busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FIN,
        S_WAIT_CLR
    } state_t;

    localparam logic [FFT_N-2:0] LAST_BIN = '1;

    // Absolute value one bit wider than the input so the most negative code
    // maps onto its true positive magnitude instead of wrapping.
    function automatic logic [FFT_DW:0] abs_ext(input logic signed [FFT_DW-1:0] x);
        logic [FFT_DW:0] xe;
        xe = {x[FFT_DW-1], x};
        return xe[FFT_DW] ? (~xe + 1'b1) : xe;
    endfunction

    // max + min/2, truncated. The sum never exceeds 1.5 * 2^(FFT_DW-1), so
    // FFT_DW+1 bits always hold it and no saturation is needed.
    function automatic logic [MAG_DW-1:0] mag_calc(input logic signed [FFT_DW-1:0] re,
                                                   input logic signed [FFT_DW-1:0] im);
        logic [FFT_DW:0] a;
        logic [FFT_DW:0] b;
        logic [FFT_DW:0] hi;
        logic [FFT_DW:0] lo;
        a = abs_ext(re);
        b = abs_ext(im);
        if (a >= b) begin
            hi = a;
            lo = b;
        end else begin
            hi = b;
            lo = a;
        end
        return MAG_DW'(hi + (lo >> 1));
    endfunction

    state_t state;
    state_t state_nxt;

    logic [FFT_N-2:0]  rd_addr;
    logic              start;
    logic              issue;
    logic              pop;
    logic              push;
    logic [2:0]        occ;

    logic              vld_p1;
    logic [FFT_N-2:0]  bin_p1;
    logic [MAG_DW-1:0] mag_p1;

    logic [FFT_N-2:0]  fifo_bin  [2];
    logic [MAG_DW-1:0] fifo_mag  [2];
    logic              fifo_last [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_count;

    assign start = (state == S_IDLE) && fft_done && enable;
    assign pop   = out_valid && out_ready;
    assign push  = vld_p1;

    // Credit check counts the read already in flight and frees the slot the
    // consumer is emptying this cycle, so a 2-entry FIFO sustains 1 bin/cycle
    // and can never be overrun.
    assign occ   = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, pop};
    assign issue = (state == S_READ) && (occ < 3'd2);

    assign dmaact = issue;
    assign dmaa   = issue ? {1'b0, rd_addr} : '0;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        fft_fin    = 1'b0;
        peak_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (fft_done && enable) state_nxt = S_READ;
            end
            S_READ: begin
                if (issue && (rd_addr == LAST_BIN)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // Leave once the FIFO will be empty after this cycle's pop,
                // which lands fft_fin one cycle after the last transfer.
                if (!vld_p1 && ((fifo_count == 2'd0) ||
                                ((fifo_count == 2'd1) && pop)))
                    state_nxt = S_FIN;
            end
            S_FIN: begin
                fft_fin    = 1'b1;
                peak_valid = 1'b1;
                state_nxt  = S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
                if (!fft_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control, frame tag and peak tracker
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_addr    <= '0;
            vld_p1     <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            out_exp    <= '0;
            peak_bin   <= '0;
            peak_mag   <= '0;
        end else begin
            vld_p1 <= issue;
            if (start) begin
                rd_addr  <= '0;
                out_exp  <= fft_bfpexp;
                peak_bin <= '0;
                peak_mag <= '0;
            end else begin
                if (issue && (rd_addr != LAST_BIN)) rd_addr <= rd_addr + 1'b1;
                // Strictly greater keeps the lowest bin on ties.
                if (pop && (out_mag > peak_mag)) begin
                    peak_mag <= out_mag;
                    peak_bin <= out_bin;
                end
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Stage p1: DMA data arrives, magnitude formed
    always_ff @(posedge clk) begin
        if (issue) bin_p1 <= rd_addr;
    end

    assign mag_p1 = mag_calc(dmadr_real, dmadr_imag);

    // Stage p2: output FIFO
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_bin[wr_ptr]  <= bin_p1;
            fifo_mag[wr_ptr]  <= mag_p1;
            fifo_last[wr_ptr] <= (bin_p1 == LAST_BIN);
        end
    end

    // Payload is forced to zero when no beat is presented so the outputs are
    // clean after reset without resetting the FIFO storage.
    assign out_valid = (fifo_count != 2'd0);
    assign out_bin   = out_valid ? fifo_bin[rd_ptr]  : '0;
    assign out_mag   = out_valid ? fifo_mag[rd_ptr]  : '0;
    assign out_last  = out_valid ? fifo_last[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_fft_spectrum_reader.sv
module tb_fft_spectrum_reader;

    localparam int FFT_LENGTH = 16;
    localparam int FFT_DW     = 16;
    localparam int FFT_N      = 4;
    localparam int MAG_DW     = 17;

    logic                     clk;
    logic                     reset;
    logic                     enable;
    logic                     fft_done;
    logic signed [7:0]        fft_bfpexp;
    logic                     fft_fin;
    logic                     dmaact;
    logic [FFT_N-1:0]         dmaa;
    logic signed [FFT_DW-1:0] rd_re;
    logic signed [FFT_DW-1:0] rd_im;
    logic                     out_valid;
    logic                     out_ready;
    logic [FFT_N-2:0]         out_bin;
    logic [MAG_DW-1:0]        out_mag;
    logic signed [7:0]        out_exp;
    logic                     out_last;
    logic                     peak_valid;
    logic [FFT_N-2:0]         peak_bin;
    logic [MAG_DW-1:0]        peak_mag;
    logic                     busy;

    fft_spectrum_reader #(.FFT_LENGTH(FFT_LENGTH), .FFT_DW(FFT_DW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fft_done(fft_done),
        .fft_bfpexp(fft_bfpexp), .fft_fin(fft_fin), .dmaact(dmaact), .dmaa(dmaa),
        .dmadr_real(rd_re), .dmadr_imag(rd_im), .out_valid(out_valid),
        .out_ready(out_ready), .out_bin(out_bin), .out_mag(out_mag),
        .out_exp(out_exp), .out_last(out_last), .peak_valid(peak_valid),
        .peak_bin(peak_bin), .peak_mag(peak_mag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural spectrum RAM, 1-cycle read latency
    logic signed [FFT_DW-1:0] ram_re [FFT_LENGTH];
    logic signed [FFT_DW-1:0] ram_im [FFT_LENGTH];
    always @(posedge clk) begin
        if (dmaact) begin
            rd_re <= ram_re[dmaa];
            rd_im <= ram_im[dmaa];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int bin;
        int mag;
        int e;
        int last;
        int cyc;
    } beat_t;

    beat_t log_q[$];
    int checks = 0;
    int errors = 0;
    int fin_count, pv_count, fin_cyc, fin_pv, fin_pbin, fin_pmag;
    int act_count, act_stall, first_act, first_vld, stab_err, max_out;
    int start_cyc;
    int exp_mag[8];
    logic prev_stall;
    logic [FFT_N-2:0] prev_bin;
    logic [MAG_DW-1:0] prev_mag;
    logic prev_last;
    logic signed [7:0] prev_exp;

    // Passive monitor, sampled mid-cycle
    always @(negedge clk) begin
        beat_t b;
        int outstanding;
        if (dmaact) begin
            act_count++;
            if (first_act < 0) first_act = cyc;
            if (!out_ready) act_stall++;
        end
        if (out_valid && first_vld < 0) first_vld = cyc;
        if (out_valid && out_ready) begin
            b.bin  = int'(out_bin);
            b.mag  = int'(out_mag);
            b.e    = int'(out_exp);
            b.last = int'(out_last);
            b.cyc  = cyc;
            log_q.push_back(b);
        end
        if (fft_fin) begin
            fin_count++;
            fin_cyc  = cyc;
            fin_pv   = int'(peak_valid);
            fin_pbin = int'(peak_bin);
            fin_pmag = int'(peak_mag);
        end
        if (peak_valid) pv_count++;
        if (prev_stall && (!out_valid || out_bin != prev_bin || out_mag != prev_mag ||
                           out_last != prev_last || out_exp != prev_exp))
            stab_err++;
        prev_stall = out_valid && !out_ready;
        prev_bin   = out_bin;
        prev_mag   = out_mag;
        prev_last  = out_last;
        prev_exp   = out_exp;
        outstanding = act_count - log_q.size();
        if (outstanding > max_out) max_out = outstanding;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        log_q.delete();
        fin_count = 0; pv_count = 0; fin_cyc = -1; fin_pv = 0; fin_pbin = -1; fin_pmag = -1;
        act_count = 0; act_stall = 0; first_act = -1; first_vld = -1;
        stab_err = 0; max_out = 0; prev_stall = 1'b0;
    endtask

    task automatic load_bin(input int k, input int re, input int im);
        ram_re[k] = re[15:0];
        ram_im[k] = im[15:0];
    endtask

    task automatic load_ramp();
        for (int k = 0; k < FFT_LENGTH; k++) load_bin(k, (k < 8) ? 100 * k : 0, 0);
        exp_mag = '{0, 100, 200, 300, 400, 500, 600, 700};
    endtask

    task automatic start_frame(input int e);
        clear_log();
        fft_bfpexp = e[7:0];
        fft_done   = 1'b1;
        start_cyc  = cyc;
    endtask

    task automatic wait_fin(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (fin_count != 0) break;
            step();
        end
        check(tag, fin_count != 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {dmaact, dmaa, out_valid, out_bin, out_mag, out_exp, out_last,
                               fft_fin, peak_valid, peak_bin, peak_mag, busy}, 0);
        check({tag, "_dmaact"}, dmaact, 0);
    endtask

    task automatic check_frame(input string tag, input int e, input int pb, input int pm);
        beat_t pad;
        check({tag, "_nbeats"}, log_q.size(), 8);
        pad.bin = -1; pad.mag = -1; pad.e = -1; pad.last = -1; pad.cyc = -100;
        while (log_q.size() < 8) log_q.push_back(pad);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_b%0d_bin", tag, i), log_q[i].bin, i);
            check($sformatf("%s_b%0d_mag", tag, i), log_q[i].mag, exp_mag[i]);
            check($sformatf("%s_b%0d_exp", tag, i), log_q[i].e, e);
            check($sformatf("%s_b%0d_last", tag, i), log_q[i].last, (i == 7) ? 1 : 0);
        end
        check({tag, "_fin_cnt"}, fin_count, 1);
        check({tag, "_pv_cnt"}, pv_count, 1);
        check({tag, "_pv_at_fin"}, fin_pv, 1);
        check({tag, "_fin_delay"}, fin_cyc - log_q[7].cyc, 1);
        check({tag, "_peak_bin"}, fin_pbin, pb);
        check({tag, "_peak_mag"}, fin_pmag, pm);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; fft_done = 1'b0; fft_bfpexp = '0; out_ready = 1'b1;
        for (int k = 0; k < FFT_LENGTH; k++) load_bin(k, 0, 0);
        clear_log();

        // Power-on reset
        steps(3);
        check_all_zero("por");
        reset = 1'b1;
        step();
        check("idle_busy", busy, 0);

        // Reset held low mid-READ aborts the frame silently
        load_ramp();
        start_frame(2);
        steps(3);
        check("abort_in_read", busy, 1);
        reset = 1'b0;
        fft_done = 1'b0;
        step();
        check_all_zero("rst_mid");
        steps(2);
        reset = 1'b1;
        step();
        check_all_zero("rst_after");
        check("abort_no_fin", fin_count, 0);
        start_frame(5);
        wait_fin("restart_fin");
        step();
        check_frame("restart", 5, 7, 700);
        fft_done = 1'b0;
        steps(2);

        // Basic streaming, fft_done held high well past FIN
        start_frame(-3);
        wait_fin("basic_fin");
        steps(6);
        check_frame("basic", -3, 7, 700);
        check("basic_act_lat", first_act - start_cyc, 1);
        check("basic_vld_lat", first_vld - first_act, 2);
        check("basic_consec", log_q[7].cyc - log_q[0].cyc, 7);
        check("basic_nreads", act_count, 8);
        check("basic_wait_busy", busy, 1);
        check("basic_hold_pmag", peak_mag, 700);
        fft_done = 1'b0;
        steps(2);
        check("basic_idle", busy, 0);

        // Backpressure: out_ready low for 5 cycles while beat 2 is presented
        start_frame(-3);
        steps(5);
        out_ready = 1'b0;
        steps(2);
        check("stall_valid", out_valid, 1);
        check("stall_bin", out_bin, 2);
        check("stall_mag", out_mag, 200);
        check("stall_noread", dmaact, 0);
        steps(3);
        out_ready = 1'b1;
        wait_fin("stall_fin");
        step();
        check_frame("stall", -3, 7, 700);
        check("stall_stable", stab_err, 0);
        check("stall_act_blocked", act_stall, 0);
        check("stall_max_buf", max_out, 2);
        check("stall_nreads", act_count, 8);
        fft_done = 1'b0;
        steps(2);

        // Magnitude arithmetic corner cases
        load_bin(0, -32768, -32768);
        load_bin(1, 3, -4);
        load_bin(2, -7, 0);
        load_bin(3, 0, 0);
        load_bin(4, 1, 1);
        load_bin(5, -1, 2);
        load_bin(6, 10, -20);
        load_bin(7, -15, -9);
        exp_mag = '{49152, 5, 7, 0, 1, 2, 25, 19};
        start_frame(0);
        wait_fin("arith_fin");
        step();
        check_frame("arith", 0, 0, 49152);
        fft_done = 1'b0;
        steps(2);

        // Peak tie: bins 2 and 5 both 900, lowest bin wins
        load_ramp();
        load_bin(2, 900, 0);
        load_bin(5, -800, 200);
        exp_mag = '{0, 100, 900, 300, 400, 900, 600, 700};
        start_frame(7);
        wait_fin("tie_fin");
        step();
        check_frame("tie", 7, 2, 900);
        fft_done = 1'b0;
        steps(2);

        // enable dropped mid-frame: frame still completes
        start_frame(1);
        steps(2);
        enable = 1'b0;
        wait_fin("en_fin");
        step();
        check_frame("en_drop", 1, 2, 900);
        fft_done = 1'b0;
        steps(2);
        check("en_idle", busy, 0);

        // enable low: a done level starts nothing
        clear_log();
        fft_done = 1'b1;
        steps(6);
        check("dis_noread", act_count, 0);
        check("dis_busy", busy, 0);
        check("dis_valid", out_valid, 0);
        fft_done = 1'b0;
        enable = 1'b1;
        steps(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
